// File: rtl/dac_pkg.sv
// Shared types and constants for the AXI-Stream to DAC playback path.
// Contents: output FSM state type, default FIFO depth / prefill level,
// and a constant-foldable clog2 used for FIFO pointer sizing.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_FIFO_DEPTH    = 16;
    localparam int unsigned DEFAULT_PREFILL_LEVEL = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dac_stream_fifo.sv
// Synchronous FIFO with registered read data.
// Ports:
//   clk_i, reset_ni  clock, asynchronous active-low reset
//   flush_i          synchronous flush, empties the FIFO
//   push_i/wdata_i   write one entry (caller guarantees not full)
//   pop_i/rdata_o    read one entry; rdata_o updates on the edge that pops
//   full_o, empty_o  status from registered pointers
//   count_o          current occupancy (0..DEPTH)
module dac_stream_fifo
    import dac_pkg::*;
#(
    parameter  int unsigned WIDTH = 257,
    parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit: equal MSBs with equal index means
    // empty, differing MSBs with equal index means full.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_o  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                rdata_o  <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/axistream_to_dac.sv
// AXI-Stream slave that buffers DMA frames and plays them out to the DAC,
// one word per dac_ready_i cycle, after a FIFO prefill.
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   dac_play_en_i            playback enable (registered once as en_q)
//   length                   expected beats per frame minus 1
//   s_axis_dac_*             AXI-Stream slave (tkeep ignored)
//   dac_ready_i              DAC consumes one word this cycle
//   dac_data_o/_valid_o      presented DAC word and its qualifier
//   frame_done_o             pulse while the tlast word is presented
//   underrun_o               pulse after a ready cycle that found the FIFO empty
//   len_err_o                sticky frame-length mismatch
module axistream_to_dac
    import dac_pkg::*;
#(
    parameter  int unsigned DAC_DWIDTH    = 256,
    parameter  int unsigned FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter  int unsigned PREFILL_LEVEL = DEFAULT_PREFILL_LEVEL,
    localparam int unsigned AW            = clog2(FIFO_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    dac_play_en_i,
    input  logic [31:0]             length,
    input  logic                    s_axis_dac_tvalid,
    output logic                    s_axis_dac_tready,
    input  logic [DAC_DWIDTH-1:0]   s_axis_dac_tdata,
    input  logic [DAC_DWIDTH/8-1:0] s_axis_dac_tkeep,
    input  logic                    s_axis_dac_tlast,
    input  logic                    dac_ready_i,
    output logic [DAC_DWIDTH-1:0]   dac_data_o,
    output logic                    dac_data_valid_o,
    output logic                    frame_done_o,
    output logic                    underrun_o,
    output logic                    len_err_o
);

    localparam logic [AW:0] PREFILL_CNT = PREFILL_LEVEL[AW:0];
    localparam logic [AW:0] CNT_ONE     = 1;

    state_t              state_q, state_d;
    logic                en_q;
    logic                accept;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         fifo_count;
    logic [DAC_DWIDTH:0] fifo_rdata;
    logic [31:0]         in_cnt_q;
    logic [AW:0]         last_pend_q;
    logic                pop_q;
    logic                valid_q;
    logic                underrun_q;
    logic                len_err_q;
    logic                frame_end;
    logic                unused_tkeep;

    assign unused_tkeep = ^s_axis_dac_tkeep;

    assign s_axis_dac_tready = en_q && !fifo_full;
    assign accept            = s_axis_dac_tvalid && s_axis_dac_tready;

    // The FIFO read register is the DAC word register; the valid flag
    // zeroes it during underrun/idle without a second pipeline stage.
    assign frame_end        = pop_q && fifo_rdata[DAC_DWIDTH];
    assign dac_data_o       = valid_q ? fifo_rdata[DAC_DWIDTH-1:0] : '0;
    assign dac_data_valid_o = valid_q;
    assign frame_done_o     = en_q && frame_end;
    assign underrun_o       = underrun_q;
    assign len_err_o        = len_err_q;

    dac_stream_fifo #(
        .WIDTH (DAC_DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .flush_i  (!en_q),
        .push_i   (accept),
        .wdata_i  ({s_axis_dac_tlast, s_axis_dac_tdata}),
        .pop_i    (fifo_pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // Input side: enable register, beat counter, length check and a count
    // of tlast words buffered but not yet presented (lets FILL release
    // frames shorter than the prefill level).
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            en_q        <= 1'b0;
            in_cnt_q    <= '0;
            last_pend_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            en_q <= dac_play_en_i;
            if (!en_q) begin
                in_cnt_q    <= '0;
                last_pend_q <= '0;
            end else begin
                if (accept) in_cnt_q <= s_axis_dac_tlast ? '0 : in_cnt_q + 32'd1;
                case ({accept && s_axis_dac_tlast, frame_end})
                    2'b10:   last_pend_q <= last_pend_q + CNT_ONE;
                    2'b01:   last_pend_q <= last_pend_q - CNT_ONE;
                    default: last_pend_q <= last_pend_q;
                endcase
            end
            if (dac_play_en_i && !en_q) begin
                len_err_q <= 1'b0;
            end else if (accept && (s_axis_dac_tlast ? (in_cnt_q != length)
                                                     : (in_cnt_q == length))) begin
                len_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (en_q) state_d = FILL;
            FILL: if (fifo_count >= PREFILL_CNT || last_pend_q != '0) state_d = PLAY;
            PLAY: begin
                // The tlast word is on the output this cycle: stop popping so
                // the next frame waits for its own prefill.
                if (frame_end)                       state_d  = IDLE;
                else if (dac_ready_i && !fifo_empty) fifo_pop = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!en_q) begin
            state_d  = IDLE;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            pop_q      <= 1'b0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pop_q      <= fifo_pop;
            underrun_q <= en_q && (state_q == PLAY) && !frame_end &&
                          dac_ready_i && fifo_empty;
            if (fifo_pop) begin
                valid_q <= 1'b1;
            end else if (!en_q || state_q != PLAY || frame_end ||
                         (dac_ready_i && fifo_empty)) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axistream_to_dac.sv
module tb_axistream_to_dac;

    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned PREFILL = 8;

    localparam int unsigned M_STEADY = 0;
    localparam int unsigned M_BACKP  = 1;
    localparam int unsigned M_STALL  = 2;
    localparam int unsigned M_RAND   = 3;

    logic            clk_i;
    logic            reset_ni;
    logic            dac_play_en_i;
    logic [31:0]     length;
    logic            s_axis_dac_tvalid;
    logic            s_axis_dac_tready;
    logic [DW-1:0]   s_axis_dac_tdata;
    logic [DW/8-1:0] s_axis_dac_tkeep;
    logic            s_axis_dac_tlast;
    logic            dac_ready_i;
    logic [DW-1:0]   dac_data_o;
    logic            dac_data_valid_o;
    logic            frame_done_o;
    logic            underrun_o;
    logic            len_err_o;

    axistream_to_dac #(
        .DAC_DWIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .PREFILL_LEVEL (PREFILL)
    ) dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .dac_play_en_i     (dac_play_en_i),
        .length            (length),
        .s_axis_dac_tvalid (s_axis_dac_tvalid),
        .s_axis_dac_tready (s_axis_dac_tready),
        .s_axis_dac_tdata  (s_axis_dac_tdata),
        .s_axis_dac_tkeep  (s_axis_dac_tkeep),
        .s_axis_dac_tlast  (s_axis_dac_tlast),
        .dac_ready_i       (dac_ready_i),
        .dac_data_o        (dac_data_o),
        .dac_data_valid_o  (dac_data_valid_o),
        .frame_done_o      (frame_done_o),
        .underrun_o        (underrun_o),
        .len_err_o         (len_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: words leave in acceptance order, one per ready cycle;
    // tready = enabled && fewer than DEPTH words held; length rule applied
    // per accepted beat; everything is discarded while disabled.
    logic [DW:0]   q[$];
    bit            mon_en = 0;
    logic          en_sample, en_m, en_prev;
    logic          lerr_m;
    logic [31:0]   in_cnt_m;
    logic          prev_ready;
    logic [DW-1:0] held;
    int            frm_words, frm_fd, frm_ur, frm_acc, first_acc;
    bit            saw_full;

    task automatic mon_init();
        q.delete();
        en_sample  = 1'b0;
        en_m       = 1'b0;
        en_prev    = 1'b0;
        lerr_m     = 1'b0;
        in_cnt_m   = '0;
        prev_ready = 1'b0;
        held       = '0;
    endtask

    task automatic clr_frame_stats();
        frm_words = 0;
        frm_fd    = 0;
        frm_ur    = 0;
        frm_acc   = 0;
        first_acc = -1;
        saw_full  = 0;
    endtask

    always @(negedge clk_i) begin
        logic [DW:0] exp_w;
        logic        pres;
        if (mon_en) begin
            en_prev   = en_m;
            en_m      = en_sample;
            en_sample = dac_play_en_i;
            if (!en_m) begin
                q.delete();
                in_cnt_m = '0;
                chk("frame_done_while_disabled", frame_done_o, 0);
            end else begin
                if (!en_prev) lerr_m = 1'b0;
                pres = dac_data_valid_o && prev_ready;
                if (pres) begin
                    frm_words++;
                    if (first_acc < 0) first_acc = frm_acc;
                    if (q.size() == 0) begin
                        chk("word_without_input", 1, 0);
                    end else begin
                        exp_w = q.pop_front();
                        chk("data_order", dac_data_o, exp_w[DW-1:0]);
                        chk("frame_done_on_word", frame_done_o, exp_w[DW]);
                    end
                end else begin
                    chk("frame_done_spurious", frame_done_o, 0);
                    if (dac_data_valid_o) chk("data_hold", dac_data_o, held);
                end
                if (frame_done_o) frm_fd++;
            end
            if (!dac_data_valid_o) chk("data_zero_when_invalid", dac_data_o, 0);
            if (underrun_o) begin
                frm_ur++;
                chk("underrun_valid_low", dac_data_valid_o, 0);
            end
            chk("len_err", len_err_o, lerr_m);
            chk("tready", s_axis_dac_tready, en_m && (q.size() < DEPTH));
            if (!s_axis_dac_tready && en_m && q.size() == DEPTH) saw_full = 1;
            if (s_axis_dac_tvalid && s_axis_dac_tready) begin
                q.push_back({s_axis_dac_tlast, s_axis_dac_tdata});
                frm_acc++;
                if (s_axis_dac_tlast) begin
                    if (in_cnt_m != length) lerr_m = 1'b1;
                    in_cnt_m = '0;
                end else begin
                    if (in_cnt_m == length) lerr_m = 1'b1;
                    in_cnt_m = in_cnt_m + 32'd1;
                end
            end
            prev_ready = dac_ready_i;
            held       = dac_data_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_frame(input logic [31:0] len, input int unsigned nbeats,
                             input int unsigned mode, input int unsigned stall_after,
                             input bit restart);
        int unsigned   beat, stall_cnt;
        logic [DW-1:0] cur;
        bit            done;
        length = len;
        if (restart) begin
            dac_play_en_i     = 1'b0;
            s_axis_dac_tvalid = 1'b0;
            dac_ready_i       = 1'b0;
            repeat (2) step();
            dac_play_en_i = 1'b1;
            repeat (2) step();
        end
        clr_frame_stats();
        beat      = 0;
        stall_cnt = 0;
        cur       = $urandom;
        done      = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            step();
            case (mode)
                M_BACKP: dac_ready_i = (cyc >= 40);
                M_RAND:  dac_ready_i = ($urandom % 4) != 0;
                default: dac_ready_i = 1'b1;
            endcase
            s_axis_dac_tvalid = 1'b0;
            if (beat < nbeats) begin
                if (mode == M_STALL && beat == stall_after && stall_cnt < 20) stall_cnt++;
                else if (mode == M_RAND) s_axis_dac_tvalid = ($urandom % 3) != 0;
                else s_axis_dac_tvalid = 1'b1;
            end
            s_axis_dac_tdata = cur;
            s_axis_dac_tlast = (beat == nbeats - 1);
            @(negedge clk_i);
            if (s_axis_dac_tvalid && s_axis_dac_tready) begin
                beat++;
                cur = $urandom;
            end
            if (beat == nbeats && frm_fd >= 1) done = 1;
        end
        if (!done) chk("frame_timeout", 0, 1);
        step();
        s_axis_dac_tvalid = 1'b0;
        dac_ready_i       = 1'b1;
        repeat (4) step();
    endtask

    typedef struct {
        logic [31:0] len;
        int unsigned nbeats;
        int unsigned mode;
        int unsigned stall;
        int unsigned exp_words;
        logic        exp_lerr;
        int unsigned exp_ur;   // 0 none, 1 at least one, 2 don't care
    } vec_t;

    vec_t tbl[8];

    initial begin
        int unsigned min_acc;
        int          fd_before;

        tbl[0] = '{32'd15, 16, M_STEADY, 0,  16, 1'b0, 0};  // nominal
        tbl[1] = '{32'd19, 20, M_BACKP,  0,  20, 1'b0, 0};  // backpressure, FIFO fills
        tbl[2] = '{32'd15, 16, M_STALL,  10, 16, 1'b0, 1};  // underrun
        tbl[3] = '{32'd2,  3,  M_STEADY, 0,  3,  1'b0, 0};  // short frame
        tbl[4] = '{32'd7,  5,  M_STEADY, 0,  5,  1'b1, 0};  // early tlast
        tbl[5] = '{32'd3,  6,  M_STEADY, 0,  6,  1'b1, 0};  // late tlast
        tbl[6] = '{32'd11, 12, M_RAND,   0,  12, 1'b0, 2};
        tbl[7] = '{32'd24, 25, M_RAND,   0,  25, 1'b0, 2};

        reset_ni          = 1'b1;
        dac_play_en_i     = 1'b0;
        length            = '0;
        s_axis_dac_tvalid = 1'b0;
        s_axis_dac_tdata  = '0;
        s_axis_dac_tkeep  = '1;
        s_axis_dac_tlast  = 1'b0;
        dac_ready_i       = 1'b0;
        #1 reset_ni = 1'b0;
        #1;
        chk("reset_valid", dac_data_valid_o, 0);
        chk("reset_data", dac_data_o, 0);
        chk("reset_frame_done", frame_done_o, 0);
        chk("reset_underrun", underrun_o, 0);
        chk("reset_len_err", len_err_o, 0);
        chk("reset_tready", s_axis_dac_tready, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        mon_init();
        mon_en = 1;

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].len, tbl[i].nbeats, tbl[i].mode, tbl[i].stall, 1'b1);
            min_acc = (tbl[i].nbeats < PREFILL) ? tbl[i].nbeats : PREFILL;
            chk($sformatf("v%0d_words", i), frm_words, tbl[i].exp_words);
            chk($sformatf("v%0d_frame_done_count", i), frm_fd, 1);
            chk($sformatf("v%0d_len_err", i), len_err_o, tbl[i].exp_lerr);
            chk($sformatf("v%0d_prefill", i), first_acc >= int'(min_acc), 1);
            if (tbl[i].exp_ur == 0) chk($sformatf("v%0d_underruns", i), frm_ur, 0);
            if (tbl[i].exp_ur == 1) chk($sformatf("v%0d_underrun_seen", i), frm_ur > 0, 1);
            if (tbl[i].mode == M_BACKP) chk($sformatf("v%0d_fifo_full_seen", i), saw_full, 1);
        end

        // len_err survives disable and clears on re-enable
        run_frame(32'd7, 5, M_STEADY, 0, 1'b1);
        chk("lerr_set", len_err_o, 1);
        dac_play_en_i = 1'b0;
        repeat (2) step();
        chk("lerr_held_while_disabled", len_err_o, 1);
        dac_play_en_i = 1'b1;
        repeat (2) step();
        chk("lerr_cleared_on_enable", len_err_o, 0);

        // Abort mid-PLAY
        length = 32'd15;
        clr_frame_stats();
        dac_ready_i = 1'b1;
        for (int cyc = 0; cyc < 200 && frm_words < 3; cyc++) begin
            step();
            s_axis_dac_tvalid = 1'b1;
            s_axis_dac_tdata  = $urandom;
            s_axis_dac_tlast  = 1'b0;
            @(negedge clk_i);
        end
        chk("abort_reached_play", frm_words >= 3, 1);
        step();
        dac_play_en_i     = 1'b0;
        s_axis_dac_tvalid = 1'b0;
        fd_before         = frm_fd;
        step();
        step();
        chk("abort_valid", dac_data_valid_o, 0);
        chk("abort_data", dac_data_o, 0);
        chk("abort_tready", s_axis_dac_tready, 0);
        repeat (5) step();
        chk("abort_no_frame_done", frm_fd, fd_before);
        dac_play_en_i = 1'b1;
        repeat (3) step();
        run_frame(32'd2, 3, M_STEADY, 0, 1'b0);
        chk("post_abort_words", frm_words, 3);
        chk("post_abort_frame_done", frm_fd, 1);

        // Asynchronous reset mid-frame (length 0 forces len_err beforehand)
        length = 32'd0;
        clr_frame_stats();
        for (int cyc = 0; cyc < 200 && frm_words < 2; cyc++) begin
            step();
            s_axis_dac_tvalid = 1'b1;
            s_axis_dac_tdata  = $urandom;
            s_axis_dac_tlast  = 1'b0;
            @(negedge clk_i);
        end
        chk("areset_reached_play", frm_words >= 2, 1);
        chk("lerr_before_reset", len_err_o, 1);
        @(posedge clk_i);
        #3;
        mon_en   = 0;
        reset_ni = 1'b0;
        #1;
        chk("areset_valid", dac_data_valid_o, 0);
        chk("areset_data", dac_data_o, 0);
        chk("areset_frame_done", frame_done_o, 0);
        chk("areset_underrun", underrun_o, 0);
        chk("areset_len_err", len_err_o, 0);
        chk("areset_tready", s_axis_dac_tready, 0);
        s_axis_dac_tvalid = 1'b0;
        dac_play_en_i     = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        mon_init();
        mon_en = 1;
        run_frame(32'd2, 3, M_STEADY, 0, 1'b1);
        chk("post_reset_words", frm_words, 3);
        chk("post_reset_frame_done", frm_fd, 1);
        chk("post_reset_len_err", len_err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axistream_to_dac.md
Name: axistream_to_dac

Overview:
- Playback-direction companion to the ADC capture path.
- Acts as an AXI-Stream slave and receives DMA MM2S frames of DAC_DWIDTH-bit words, each frame terminated by tlast.
- Buffers the words in a small FIFO and releases them to the DAC datapath one word per dac_ready_i cycle.
- Reports frame completion, underruns and frame-length mismatches.

Parameters:
- DAC_DWIDTH, 256, width of the stream word and the DAC word.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, minimum 4.
- PREFILL_LEVEL, 8, FIFO occupancy required before playback starts; must satisfy 1 <= PREFILL_LEVEL <= FIFO_DEPTH.

Ports:
- clk_i  in  1  single clock for the whole block.
- reset_ni  in  1  asynchronous reset, active low.
- dac_play_en_i  in  1  playback enable; registered once internally before use.
- length  in  32  expected beats per frame minus 1.
- s_axis_dac_tvalid  in  1  stream valid.
- s_axis_dac_tready  out  1  stream ready.
- s_axis_dac_tdata  in  DAC_DWIDTH  stream data.
- s_axis_dac_tkeep  in  DAC_DWIDTH/8  byte enables; ignored, all bytes treated as valid.
- s_axis_dac_tlast  in  1  end of frame.
- dac_ready_i  in  1  DAC consumes one word this cycle.
- dac_data_o  out  DAC_DWIDTH  registered DAC word.
- dac_data_valid_o  out  1  dac_data_o holds a real sample.
- frame_done_o  out  1  one-cycle pulse when the tlast word is presented on dac_data_o.
- underrun_o  out  1  one-cycle pulse when dac_ready_i is high in PLAY and the FIFO is empty.
- len_err_o  out  1  sticky frame-length mismatch flag.

Behaviour:
Reset and enable
- Reset (reset_ni low, asynchronous): all outputs 0, s_axis_dac_tready 0, FIFO empty, beat counter 0, state IDLE.
- en_q is dac_play_en_i delayed one clk_i.

Input side
- s_axis_dac_tready = en_q && !fifo_full. This is combinational from registered state.
- A beat is accepted when tvalid && tready. It pushes {tlast, tdata} into the FIFO (DAC_DWIDTH+1 bits wide).
- in_cnt (32-bit) counts accepted beats in the current frame.
- If a tlast beat arrives with in_cnt != length: set len_err_o. The frame is still played and terminated at that tlast.
- If a non-tlast beat arrives with in_cnt == length: set len_err_o and keep accepting until tlast.
- in_cnt clears on every accepted tlast beat.
- len_err_o clears only on reset or on a rising edge of en_q.

Output FSM
- IDLE:
  - dac_data_valid_o = 0, dac_data_o = 0.
  - If en_q, go to FILL.
- FILL:
  - Outputs held at 0.
  - Go to PLAY when fifo_count >= PREFILL_LEVEL, or when the FIFO contains a tlast word (covers frames shorter than the prefill level).
- PLAY, on each cycle with dac_ready_i:
  - FIFO non-empty: pop. Next cycle dac_data_o = word and dac_data_valid_o = 1 (latency 1 from pop).
  - Popped word has last = 1: frame_done_o pulses in the same cycle the word is presented, and the state moves to IDLE. With en_q still high, the next FILL starts on the following cycle.
  - FIFO empty: underrun_o pulses, dac_data_o = 0, dac_data_valid_o = 0, stay in PLAY (no re-prefill).
- PLAY, on a cycle with !dac_ready_i: dac_data_o and dac_data_valid_o hold their values. No pop.

Enable and FIFO corner cases
- en_q falling in any state aborts within one cycle:
  - FIFO flushed, in_cnt cleared.
  - dac_data_o and dac_data_valid_o = 0.
  - State IDLE.
  - tready is already low.
  - No frame_done_o is generated.
- Simultaneous push and pop: fifo_count is unchanged. A push into an empty FIFO is not poppable the same cycle (one-cycle write-to-read latency). Push on full is impossible by construction of tready.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. The full/empty test compares the MSBs.

Decomposition:
- dac_pkg:
  - state enum {IDLE, FILL, PLAY}.
  - Default constants for PREFILL_LEVEL and FIFO_DEPTH.
  - Function clog2 for pointer sizing.
- Sub-module dac_stream_fifo:
  - Synchronous FIFO, parameterised width and depth.
  - Registered read data, count output.
  - Synchronous flush input; async active-low reset.
- Top level holds the input counter, the length checker, the FSM and the output registers.

Test Plan:
- Nominal frame: length=15, 16 beats with tlast on the 16th, dac_ready_i always 1, PREFILL_LEVEL=8 -> PLAY entered once 8 words are buffered; 16 consecutive valid words out in order; frame_done_o pulses with word 15; len_err_o stays 0.
- Backpressure: dac_ready_i held 0 during FILL/PLAY, source streaming continuously -> tready drops after 16 words buffered; no data loss; output resumes in order once dac_ready_i returns to 1.
- Underrun: source stalls after 10 beats of a 16-beat frame -> underrun_o pulses each ready cycle with an empty FIFO; dac_data_valid_o = 0 and dac_data_o = 0 during those cycles; remaining 6 words play after the source resumes; frame_done_o pulses once.
- Short frame: length=2, 3 beats with tlast -> PLAY entered before the prefill level is reached; 3 words out.
- Length mismatch: length=7 with tlast on beat 5 -> len_err_o = 1; 5 words played; frame_done_o pulses once. Then toggle dac_play_en_i 0 -> 1 -> len_err_o clears.
- Abort and reset: dac_play_en_i deasserted mid-PLAY -> outputs zero and FIFO empty within 2 cycles, no frame_done_o. Then reset_ni asserted asynchronously mid-frame -> all outputs 0 immediately, without waiting for a clock edge.
